// File: rtl/uart_word_tx.sv
// 128-bit word to 8N1 UART serializer, MSB byte first, one active plus one pending word; line/busy lag state by one cycle.
// Latency: start bit appears two edges after an idle strobe. Backpressure: a strobe with both slots full is discarded and flagged on dropped.
module uart_word_tx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [127:0] tx_data,
   input  logic         tx_wr_out,
   output logic         UART_TX,
   output logic         busy,
   output logic         dropped
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  baud_cnt;
   logic [2:0]     bit_idx;
   logic [3:0]     byte_idx;
   logic [127:0]   shift_word;
   logic [127:0]   pend_word;
   logic           pend_valid;

   logic           baud_wrap;
   logic           last_wrap;
   logic           load_new;
   logic           load_pend;
   logic           pend_set;
   logic           pend_clr;
   logic           drop;
   logic           line_nxt;
   logic [7:0]     cur_byte;

   assign baud_wrap = (baud_cnt == CW'(CLKS_PER_BIT - 1));
   assign last_wrap = (state == STOP) && baud_wrap && (byte_idx == 4'd15);
   // 15 - byte_idx == ~byte_idx, so this selects shift_word[127-8*byte_idx -: 8]
   assign cur_byte  = shift_word[{~byte_idx, 3'b000} +: 8];

   always_comb begin
      state_nxt = state;
      load_new  = 1'b0;
      load_pend = 1'b0;
      pend_set  = 1'b0;
      pend_clr  = 1'b0;
      drop      = 1'b0;
      line_nxt  = 1'b1;
      case (state)
         IDLE: begin
            if (tx_wr_out) begin
               load_new  = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            line_nxt = 1'b0;
            if (baud_wrap) state_nxt = DATA;
         end
         DATA: begin
            line_nxt = cur_byte[bit_idx];
            if (baud_wrap && bit_idx == 3'd7) state_nxt = STOP;
         end
         STOP: begin
            if (baud_wrap) begin
               if (byte_idx != 4'd15) begin
                  state_nxt = START;
               end else if (pend_valid) begin
                  load_pend = 1'b1;
                  state_nxt = START;
               end else if (tx_wr_out) begin
                  load_new  = 1'b1;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // the final stop-bit wrap frees the pending slot in the same cycle
      if (tx_wr_out && state != IDLE) begin
         if (!pend_valid) begin
            if (!load_new) pend_set = 1'b1;
         end else if (last_wrap) begin
            pend_set = 1'b1;
         end else begin
            drop = 1'b1;
         end
      end
      if (load_pend && !tx_wr_out) pend_clr = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         byte_idx   <= '0;
         pend_valid <= 1'b0;
         dropped    <= 1'b0;
         UART_TX    <= 1'b1;
         busy       <= 1'b0;
      end else begin
         state   <= state_nxt;
         dropped <= drop;
         UART_TX <= line_nxt;
         busy    <= (state != IDLE) | pend_valid;

         if (state == IDLE || baud_wrap) baud_cnt <= '0;
         else                            baud_cnt <= baud_cnt + CW'(1);

         if (state == START && baud_wrap)     bit_idx <= '0;
         else if (state == DATA && baud_wrap) bit_idx <= bit_idx + 3'd1;

         if (load_new || load_pend)           byte_idx <= '0;
         else if (state == STOP && baud_wrap) byte_idx <= byte_idx + 4'd1;

         if (pend_set)      pend_valid <= 1'b1;
         else if (pend_clr) pend_valid <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (load_new)       shift_word <= tx_data;
      else if (load_pend) shift_word <= pend_word;
      if (pend_set)       pend_word  <= tx_data;
   end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: per-cycle comparison against a schedule-based line model, plus a UART decoder
// checking byte streams from a scenario table and hand-written reset sequences.
module tb_uart_word_tx;

   localparam int C  = 4;
   localparam int WC = 160 * C;

   logic         clock = 1'b0;
   logic         reset;
   logic         tx_wr_out;
   logic [127:0] tx_data;
   logic         UART_TX;
   logic         busy;
   logic         dropped;

   always #5 clock = ~clock;

   uart_word_tx #(.CLKS_PER_BIT(C)) dut (
      .clock     (clock),
      .reset     (reset),
      .tx_data   (tx_data),
      .tx_wr_out (tx_wr_out),
      .UART_TX   (UART_TX),
      .busy      (busy),
      .dropped   (dropped)
   );

   typedef struct {
      logic [127:0] w0;
      int           gap1;
      logic [127:0] w1;
      int           gap2;
      logic [127:0] w2;
      int           exp_words;
      int           exp_drops;
   } vec_t;

   int     n_tests = 0;
   int     n_fail  = 0;
   longint cyc     = 0;

   // model: a word occupies line cycles [m_t0, m_t0+WC)
   logic         m_act = 1'b0;
   longint       m_t0  = 0;
   logic [127:0] m_word;
   logic         m_pv  = 1'b0;
   logic [127:0] m_pend;
   logic [127:0] m_sent[$];
   logic         exp_tx, exp_busy, exp_drop;

   logic [7:0]   rx_q[$];
   logic         rx_act = 1'b0;
   int           rx_cnt;
   logic [7:0]   rx_sh;
   int           drops_seen;
   longint       fall_cyc, busy_low_cyc;

   function automatic logic frame_bit(input logic [127:0] w, input longint pos);
      int pb  = int'(pos / C);
      int byt = pb / 10;
      int b   = pb % 10;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return w[120 - 8*byt + b - 1];
   endfunction

   function automatic logic [127:0] rnd_word();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic check(input string name, input longint got, input longint want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic start_word(input logic [127:0] w);
      m_word = w;
      m_t0   = cyc + 1;
      m_sent.push_back(w);
   endtask

   task automatic step(input logic rst, input logic stb, input logic [127:0] d);
      reset     = rst;
      tx_wr_out = stb;
      tx_data   = d;
      @(posedge clock);
      exp_drop = 1'b0;
      if (rst) begin
         exp_tx   = 1'b1;
         exp_busy = 1'b0;
         m_act    = 1'b0;
         m_pv     = 1'b0;
      end else begin
         exp_tx   = m_act ? frame_bit(m_word, cyc - m_t0) : 1'b1;
         exp_busy = m_act || m_pv;
         if (m_act && cyc == m_t0 + WC - 1) begin
            if (m_pv) begin
               start_word(m_pend);
               if (stb) m_pend = d;
               else     m_pv   = 1'b0;
            end else if (stb) begin
               start_word(d);
            end else begin
               m_act = 1'b0;
            end
         end else if (!m_act) begin
            if (stb) begin
               m_act = 1'b1;
               start_word(d);
            end
         end else if (stb) begin
            if (!m_pv) begin
               m_pv   = 1'b1;
               m_pend = d;
            end else begin
               exp_drop = 1'b1;
            end
         end
      end
      #1;
      n_tests++;
      if ({UART_TX, busy, dropped} !== {exp_tx, exp_busy, exp_drop}) begin
         n_fail++;
         $display("FAIL cycle %0d line/busy/dropped: got %b%b%b, want %b%b%b",
                  cyc, UART_TX, busy, dropped, exp_tx, exp_busy, exp_drop);
      end
      if (dropped === 1'b1) drops_seen++;
      if (rst) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (UART_TX === 1'b0) begin
            rx_act = 1'b1;
            rx_cnt = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % C == C/2 && rx_cnt / C >= 1 && rx_cnt / C <= 8)
            rx_sh[rx_cnt / C - 1] = UART_TX;
         if (rx_cnt == 9*C + C/2) begin
            rx_q.push_back(rx_sh);
            rx_act = 1'b0;
         end
      end
      if (UART_TX === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
      if (fall_cyc >= 0 && busy_low_cyc < 0 && busy === 1'b0) busy_low_cyc = cyc;
      cyc++;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int s1, s2, t;
      logic [127:0] wl[3];
      logic [7:0]   exp_q[$];
      int           nw, bad;
      bit           done;
      wl[0] = v.w0; wl[1] = v.w1; wl[2] = v.w2;
      s1 = (v.gap1 >= 0) ? v.gap1 : -1;
      s2 = (s1 >= 0 && v.gap2 >= 0) ? s1 + v.gap2 : -1;
      rx_q.delete();
      m_sent.delete();
      drops_seen   = 0;
      fall_cyc     = -1;
      busy_low_cyc = -1;
      done         = 1'b0;
      for (t = 0; t < 5000 && !done; t++) begin
         if (t == 0)       step(1'b0, 1'b1, v.w0);
         else if (t == s1) step(1'b0, 1'b1, v.w1);
         else if (t == s2) step(1'b0, 1'b1, v.w2);
         else              step(1'b0, 1'b0, '0);
         if (t > s1 && t > s2 && busy === 1'b0 && !m_act && !m_pv && !rx_act) done = 1'b1;
      end
      check($sformatf("vec%0d completes in budget", idx), done, 1);
      nw = (v.exp_words >= 0) ? v.exp_words : m_sent.size();
      for (int k = 0; k < nw * 16; k++)
         exp_q.push_back((v.exp_words >= 0) ? wl[k/16][127 - 8*(k%16) -: 8]
                                            : m_sent[k/16][127 - 8*(k%16) -: 8]);
      check($sformatf("vec%0d byte count", idx), rx_q.size(), exp_q.size());
      bad = -1;
      for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++)
         if (bad < 0 && rx_q[k] !== exp_q[k]) bad = k;
      check($sformatf("vec%0d first bad byte index (-1 none)", idx), bad, -1);
      if (v.exp_drops >= 0)
         check($sformatf("vec%0d dropped pulses", idx), drops_seen, v.exp_drops);
      if (idx == 0)
         check("single word busy-low minus start fall", busy_low_cyc - fall_cyc, WC);
   endtask

   vec_t vecs[8];
   logic [127:0] wa, wb, wc;

   initial begin
      wa = 128'hBE9B6F8BBE9B6F8B_3FBD7B2D3FBD7B2D;
      wb = rnd_word();
      wc = rnd_word();
      vecs[0] = '{wa, -1, '0, -1, '0, 1, 0};            // single word
      vecs[1] = '{wa, 100, wb, -1, '0, 2, 0};           // pending word
      vecs[2] = '{wa, 1, wb, 1, wc, 2, 1};              // overflow: C dropped
      vecs[3] = '{wb, WC, wc, -1, '0, 2, 0};            // strobe on final wrap, slot empty
      vecs[4] = '{wa, 5, wb, WC-5, wc, 3, 0};           // strobe on final wrap, slot full
      vecs[5] = '{wc, WC-1, wa, -1, '0, 2, 0};          // one edge before final wrap
      vecs[6] = '{rnd_word(), int'($urandom_range(1, 1300)), rnd_word(),
                  int'($urandom_range(1, 1300)), rnd_word(), -1, -1};
      vecs[7] = '{rnd_word(), int'($urandom_range(1, 40)), rnd_word(),
                  int'($urandom_range(1, 700)), rnd_word(), -1, -1};

      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
      for (int i = 0; i < 5; i++)  step(1'b0, 1'b0, '0);
      check("idle line after reset", UART_TX, 1);
      check("idle busy after reset", busy, 0);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // reset during byte 5 bit 3 with a pending word held
      rx_q.delete();
      step(1'b0, 1'b1, wa);
      for (int i = 0; i < 100; i++) step(1'b0, 1'b0, '0);
      step(1'b0, 1'b1, wb);
      while (cyc < m_t0 + (5*10 + 1 + 3)*C + 1) step(1'b0, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      check("line right after mid-frame reset", UART_TX, 1);
      check("busy right after mid-frame reset", busy, 0);
      for (int i = 0; i < 3*WC; i++) step(1'b0, 1'b0, '0);
      check("pending word lost after reset (busy)", busy, 0);
      check("pending word lost after reset (bytes)", rx_q.size(), 5);
      run_vec(vecs[0], 8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Serializes 128-bit result words from `computation_master` onto an 8N1 UART line. Each `tx_wr_out` strobe hands over one word on `tx_data`. The block holds one word in flight plus one pending word, and emits the word as 16 bytes, most-significant byte first. It is the transmit-side counterpart to the word receive path (`rx_data` / `rx_irq`) and drives the board-level UART TX pin.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `clock` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `tx_data` input 128: word to send; sampled only in cycles where `tx_wr_out` = 1.
- `tx_wr_out` input 1: one-cycle write strobe; a multi-cycle high is treated as one strobe per cycle.
- `UART_TX` output 1: serial line; idle high; registered.
- `busy` output 1: high while a word is being shifted or a pending word is held.
- `dropped` output 1: one-cycle pulse when a strobe is discarded because both slots are full.

## Operation
- Storage:
  - `shift_word[127:0]`: the active word.
  - `pend_word[127:0]` plus `pend_valid`: the pending slot.
- Counters:
  - `baud_cnt`: 0..CLKS_PER_BIT-1.
  - `bit_idx`: 0..7.
  - `byte_idx`: 0..15.
- States:
  - `IDLE`: `UART_TX` = 1.
    - On strobe: load `shift_word`, clear `byte_idx`, go to `START`.
  - `START`: `UART_TX` = 0 for CLKS_PER_BIT cycles, then go to `DATA` with `bit_idx` = 0.
  - `DATA`: `UART_TX` = current byte bit `[bit_idx]`, LSB first, each bit held CLKS_PER_BIT cycles.
    - After bit 7, go to `STOP`.
    - Current byte is `shift_word[127-8*byte_idx -: 8]`.
  - `STOP`: `UART_TX` = 1 for CLKS_PER_BIT cycles. At the end:
    - If `byte_idx` < 15: increment `byte_idx` and go to `START`. There is no idle gap between bytes.
    - If `byte_idx` = 15 and a next word is available (`pend_valid`, or a strobe in that same cycle): load it, go to `START`.
    - Otherwise go to `IDLE`.
- Accept rules for a strobe:
  - In `IDLE` with `pend_valid` = 0: the word goes to `shift_word`.
  - Outside `IDLE` with `pend_valid` = 0: the word goes to `pend_word` and `pend_valid` is set.
  - With `pend_valid` = 1 and the slot not freed this cycle: the word is discarded, `dropped` = 1 for one cycle, and the held data is unchanged.
- Final-stop-bit cycle (end of byte 15):
  - `pend_valid` = 1 and strobe: `pend_word` moves to `shift_word` and the new word moves to `pend_word`. No drop.
  - `pend_valid` = 1, no strobe: `pend_word` moves to `shift_word` and `pend_valid` is cleared.
  - `pend_valid` = 0 and strobe: the new word goes directly to `shift_word`.
- `busy` = (state ≠ `IDLE`) | `pend_valid`.
- Reset mid-frame:
  - Return to `IDLE`; `UART_TX` = 1 the next cycle.
  - Clear `pend_valid`, all counters, and `dropped`.
  - The partial byte is abandoned. No attempt is made to complete it.

## Timing
- Reset values: `UART_TX` = 1, `busy` = 0, `dropped` = 0, state `IDLE`, `pend_valid` = 0.
- Strobe sampled at edge N while in `IDLE`:
  - `UART_TX` falls and `busy` rises after edge N+1.
  - A strobe accepted in `IDLE` is not dropped, regardless of `reset` timing, unless `reset` is high at that edge.
- Byte frame is 10·CLKS_PER_BIT cycles. Word is 160·CLKS_PER_BIT cycles from the start-bit fall to the end of the last stop bit.
- Back-to-back words: the next start bit begins on the cycle immediately after the last stop bit of the previous word.
- `dropped` is asserted the cycle after the offending strobe edge and lasts exactly one cycle.
- `baud_cnt` wraps from CLKS_PER_BIT-1 to 0. The bit/state advance happens on the wrap cycle only.

## Test plan
- **Reset values:** assert `reset` for 10 cycles → `UART_TX` = 1, `busy` = 0, `dropped` = 0 throughout and after.
- **Single word:**
  - Stimulus: CLKS_PER_BIT = 4; strobe `tx_data` = 128'hBE9B6F8BBE9B6F8B_3FBD7B2D3FBD7B2D.
  - Line: start at the next cycle; the first byte shows bits 0,1,1,1,1,1,0,1 (0xBE); the last byte is 0x2D.
  - `busy` drops exactly 640 cycles after the start-bit fall.
  - Decoded bytes in order are BE 9B 6F 8B BE 9B 6F 8B 3F BD 7B 2D 3F BD 7B 2D.
- **Pending word:**
  - Stimulus: strobe word A; strobe word B 100 cycles later.
  - Response: B's first start bit begins at cycle 640 after A's start with no idle high; no `dropped`; `busy` stays continuously high across 1280 cycles.
- **Overflow:**
  - Stimulus: strobe A, B, C on three consecutive cycles.
  - Response: `dropped` pulses once (for C); the line carries A then B only.
- **Boundary strobe:**
  - Stimulus: strobe exactly on A's final stop-bit wrap cycle with `pend_valid` = 0.
  - Response: the new word starts with no gap; no `dropped`.
  - Repeat with `pend_valid` = 1: pending goes out first, the strobed word goes out next, no drop.
- **Reset mid-frame:**
  - Stimulus: assert `reset` for one cycle during byte 5, bit 3.
  - Response: `UART_TX` = 1 and `busy` = 0 on the next cycle; a pending word is lost.
  - A subsequent strobe transmits a clean new word starting at byte 0.
